acc_drain: RTL and testbench
============================

Name: acc_drain

Overview:
- Read-side engine for the 32-bit accumulator RAM (byte-addressed, 13-bit address, word = addr[12:2], 1-cycle synchronous read).
- On a start command, reads a contiguous block of accumulator words and streams them out on a valid/ready interface to the result/output path.
- Yields the single RAM port to the accumulator writer whenever that writer is busy.

Parameters:
- ADDR_W, 13, RAM byte-address width.
- DATA_W, 32, RAM word width.
- LEN_W, 12, word-count width (max 2048 words).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle command strobe; ignored unless idle.
- base_addr_i  in  ADDR_W  start byte address; bits [1:0] ignored (forced 0).
- len_i  in  LEN_W  number of words to drain.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse after the last word is accepted downstream.
- wr_busy_i  in  1  accumulator writer owns the RAM this cycle.
- ram_en_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM read/write byte address.
- ram_wdata_o  out  DATA_W  RAM write data (0 unless clear feature active).
- ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after the read.
- m_valid_o  out  1  output word valid.
- m_data_o  out  DATA_W  output word.
- m_last_o  out  1  marks the final word of the block.
- m_ready_i  in  1  downstream accept.

Behaviour:
- Reset: busy_o=0, done_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, m_valid_o=0, m_data_o=0, m_last_o=0; FIFO empty, in-flight flag cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE --start_i--> RUN. Latch base & ~3 as the address and len_i as issue_cnt and out_cnt.
  - start_i with len_i=0: stay in IDLE, pulse done_o next cycle, issue no reads.
  - RUN --last read issued--> DRAIN.
  - DRAIN --last word accepted (m_valid_o & m_ready_i & m_last_o)--> IDLE with done_o pulse.
- Read issue (RUN only): issue when issue_cnt != 0, wr_busy_i = 0, and credit > 0.
  - credit = 2 - fifo_count - inflight + pop_this_cycle.
  - Issue drives ram_en_o=1, ram_we_o=0, ram_addr_o=addr; then addr += 4 and issue_cnt -= 1.
- wr_busy_i=1: drain drives ram_en_o=0 and ram_we_o=0 that cycle, issues nothing, and loses no state.
- Return path: inflight is set on issue. The next cycle ram_rdata_i is pushed into a 2-entry FIFO.
- FIFO sizing: the credit rule guarantees the FIFO never overflows, and throughput is 1 word/cycle with m_ready_i held high.
- Output:
  - m_valid_o = FIFO non-empty; m_data_o = FIFO head.
  - m_last_o when out_cnt == 1; out_cnt decrements on each accept.
  - m_data_o and m_last_o stay stable while m_valid_o & ~m_ready_i.
- Latency: start_i at cycle 0 → first read cycle 1 → first m_valid_o cycle 3 (registered FIFO output).
- Address wrap: addr wraps modulo 2^ADDR_W; no error.
- start_i while busy_o: ignored.
- Reset mid-block: everything returns to reset values immediately; no done_o pulse.

Optional Feature:
- Macro ACC_DRAIN_CLEAR_EN.
- Defined (clear-after-read): after each read issue, the next RAM-owned cycle writes zero to the same address (ram_en_o=1, ram_we_o=1, ram_wdata_o=0).
  - Reads and clears alternate, so peak throughput is 1 word per 2 cycles.
  - A clear deferred by wr_busy_i stays pending, and the next read waits for it.
  - done_o fires only after the final clear is written.
- Undefined: ram_we_o is tied 0 and ram_wdata_o is tied 0.

Decomposition:
- Package acc_drain_pkg holds:
  - ADDR_W, DATA_W, LEN_W defaults;
  - the FSM state enum (IDLE/RUN/DRAIN);
  - WORD_BYTES=4 as the address increment.
- Sub-module acc_drain_fifo: 2-entry DATA_W+1 (data+last) FIFO with push/pop/count. Everything else stays in acc_drain.

Test Plan:
- base=0x040, len=4, m_ready_i=1, wr_busy_i=0 → reads at 0x040/044/048/04C on consecutive cycles; 4 words back-to-back; m_last_o on the 4th; done_o one cycle after the last accept.
- len=0 → no ram_en_o; done_o pulses once; busy_o stays 0.
- len=8 with m_ready_i toggling 1,0,0,1… → FIFO never exceeds 2 entries; data stable while stalled; all 8 words delivered in order.
- wr_busy_i high for 3 cycles mid-block → ram_en_o low during those cycles, reads resume at the next address, no word dropped or duplicated.
- base=0x1FFC, len=2 → reads at 0x1FFC then 0x0000.
- ACC_DRAIN_CLEAR_EN, base=0x100, len=3 → read and write-zero alternate at 0x100/104/108; a re-drain of the same block returns all zeros.

Source files
------------

// File: rtl/acc_drain_pkg.sv
// Shared widths, FSM encoding and address step for the accumulator drain engine.
// Optional clear-after-read behaviour is selected in acc_drain by ACC_DRAIN_CLEAR_EN.
package acc_drain_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 12;

  localparam int WORD_BYTES = 4;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/acc_drain_fifo.sv
// Two-entry return FIFO with registered head; carries one RAM word plus its last flag.
module acc_drain_fifo
  import acc_drain_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // NOTE: the storage is reset too, because the head drives m_data_o directly and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/acc_drain.sv
// Accumulator RAM drain: streams a contiguous word block out on valid/ready, yielding the RAM to the writer.
// Define ACC_DRAIN_CLEAR_EN to write zero back after each read (clear-after-read).
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              wr_busy_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
`ifdef ACC_DRAIN_CLEAR_EN
  logic              clear_pend_q, clear_pend_d;
  logic              clear_fire;
`endif

  logic              issue;
  logic              accept;
  logic              credit_ok;
  logic              all_out;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] addr_step;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;

  assign accept    = fifo_valid & m_ready_i;
  // A slot is free if FIFO plus in-flight read leaves room, counting the word leaving this cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok = occupancy < (3'(FIFO_DEPTH) + {2'b00, accept});
  assign addr_step = addr_q + ADDR_W'(WORD_BYTES);
  assign all_out   = (out_cnt_q == '0) || (accept && (out_cnt_q == LEN_W'(1)));

`ifdef ACC_DRAIN_CLEAR_EN
  assign issue      = (state_q == RUN) && (issue_cnt_q != '0) && !wr_busy_i
                      && credit_ok && !clear_pend_q;
  assign clear_fire = (state_q == RUN) && clear_pend_q && !wr_busy_i;
  assign ram_en_o   = issue | clear_fire;
  assign ram_we_o   = clear_fire;
`else
  assign issue    = (state_q == RUN) && (issue_cnt_q != '0) && !wr_busy_i && credit_ok;
  assign ram_en_o = issue;
  assign ram_we_o = 1'b0;
`endif
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = '0;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    issue_cnt_d     = issue_cnt_q;
    out_cnt_d       = out_cnt_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && (issue_cnt_q == LEN_W'(1));
`ifdef ACC_DRAIN_CLEAR_EN
    clear_pend_d    = clear_pend_q;
`endif
    if (accept) begin
      out_cnt_d = out_cnt_q - LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            addr_d      = base_addr_i & ~ADDR_W'(WORD_BYTES - 1);
            issue_cnt_d = len_i;
            out_cnt_d   = len_i;
          end
        end
      end
      RUN: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q - LEN_W'(1);
        end
`ifdef ACC_DRAIN_CLEAR_EN
        // The address only advances once the matching clear has been written.
        if (issue) begin
          clear_pend_d = 1'b1;
        end
        if (clear_fire) begin
          clear_pend_d = 1'b0;
          addr_d       = addr_step;
          if (issue_cnt_q == '0) begin
            state_d = DRAIN;
          end
        end
`else
        if (issue) begin
          addr_d = addr_step;
          if (issue_cnt_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
`endif
      end
      DRAIN: begin
        if (all_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      out_cnt_q       <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef ACC_DRAIN_CLEAR_EN
      clear_pend_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      issue_cnt_q     <= issue_cnt_d;
      out_cnt_q       <= out_cnt_d;
      done_q          <= done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
`ifdef ACC_DRAIN_CLEAR_EN
      clear_pend_q    <= clear_pend_d;
`endif
    end
  end

  acc_drain_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, ram_rdata_i}),
    .pop_i      (accept),
    .valid_o    (fifo_valid),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign m_valid_o = fifo_valid;
  assign m_data_o  = fifo_head[DATA_W-1:0];
  assign m_last_o  = fifo_valid & fifo_head[DATA_W];

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain with a read-address / output-word scoreboard and a behavioural RAM.
// Covers ACC_DRAIN_CLEAR_EN builds as well when that macro is defined.
module tb_acc_drain;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o;
  logic          wr_busy_i = 1'b0;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;
  logic          m_valid_o, m_last_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b1;

  acc_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wr_busy_i  (wr_busy_i),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return (32'(i) * 32'h0001_0101) ^ 32'h5A00_00F0;
  endfunction

  // Behavioural RAM: unwritten words read back as pat(index).
  logic [DW-1:0] ram [2048];
  bit            ram_wr [2048];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        ram[ram_addr_o[AW-1:2]]    <= ram_wdata_o;
        ram_wr[ram_addr_o[AW-1:2]] <= 1'b1;
      end else begin
        ram_rdata_i <= ram_wr[ram_addr_o[AW-1:2]] ? ram[ram_addr_o[AW-1:2]]
                                                  : pat(int'(ram_addr_o[AW-1:2]));
      end
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            reads = 0;
  int            writes = 0;
  int            accepts = 0;
  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_data_q [$];
  logic [DW-1:0] model [2048];
  bit            clr_pend = 1'b0;
  logic [AW-1:0] clr_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Per-cycle scoreboard, sampled at the falling edge.
  task automatic monitor();
    if (!rst_n) return;
    check("wdata_zero", 64'(ram_wdata_o), 64'd0);
`ifndef ACC_DRAIN_CLEAR_EN
    check("we_low", 64'(ram_we_o), 64'd0);
`endif
    if (ram_en_o && !ram_we_o) begin
      reads++;
      check("read_expected", 64'(exp_addr_q.size() != 0), 64'd1);
      if (exp_addr_q.size() != 0) check("read_addr", 64'(ram_addr_o), 64'(exp_addr_q.pop_front()));
`ifdef ACC_DRAIN_CLEAR_EN
      check("read_without_clear_pending", 64'(clr_pend), 64'd0);
      clr_pend = 1'b1;
      clr_addr = ram_addr_o;
`endif
    end
`ifdef ACC_DRAIN_CLEAR_EN
    if (ram_en_o && ram_we_o) begin
      writes++;
      check("clear_pending", 64'(clr_pend), 64'd1);
      check("clear_addr", 64'(ram_addr_o), 64'(clr_addr));
      clr_pend = 1'b0;
    end
`endif
    if (m_valid_o) begin
      check("word_expected", 64'(exp_data_q.size() != 0), 64'd1);
      if (exp_data_q.size() != 0) begin
        check("word_data", 64'(m_data_o), 64'(exp_data_q[0][DW-1:0]));
        check("word_last", 64'(m_last_o), 64'(exp_data_q[0][DW]));
        if (m_ready_i) begin
          void'(exp_data_q.pop_front());
          accepts++;
        end
      end
    end
    check("outstanding_le2", 64'((reads - accepts) <= 2), 64'd1);
  endtask

  task automatic to_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    to_neg();
    to_next();
  endtask

  task automatic start_block(input logic [AW-1:0] base, input logic [LW-1:0] len);
    logic [10:0] idx;
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len;
    for (int i = 0; i < int'(len); i++) begin
      idx = base[AW-1:2] + 11'(i);
      exp_addr_q.push_back({idx, 2'b00});
      exp_data_q.push_back({(i == int'(len) - 1), model[idx]});
`ifdef ACC_DRAIN_CLEAR_EN
      model[idx] = '0;
`endif
    end
    cycle();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      m_ready_i = toggle ? (k % 3 == 0) : 1'b1;
      to_neg();
      if (done_o) seen = 1'b1;
      to_next();
    end
    m_ready_i = 1'b1;
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) model[i] = pat(i);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ram_en", 64'(ram_en_o), 64'd0);
    check("rst_ram_we", 64'(ram_we_o), 64'd0);
    check("rst_ram_addr", 64'(ram_addr_o), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata_o), 64'd0);
    check("rst_m_valid", 64'(m_valid_o), 64'd0);
    check("rst_m_data", 64'(m_data_o), 64'd0);
    check("rst_m_last", 64'(m_last_o), 64'd0);
    to_next();
    rst_n = 1'b1;
    cycle();

    // Basic block: reads cycles 1-4, words valid 3-6, done at 7
    start_block(13'h040, 12'd4);
`ifndef ACC_DRAIN_CLEAR_EN
    for (int c = 1; c <= 8; c++) begin
      to_neg();
      check("t1_ram_en", 64'(ram_en_o), 64'(c <= 4));
      check("t1_m_valid", 64'(m_valid_o), 64'(c >= 3 && c <= 6));
      check("t1_m_last", 64'(m_last_o), 64'(c == 6));
      check("t1_done", 64'(done_o), 64'(c == 7));
      check("t1_busy", 64'(busy_o), 64'(c <= 6));
      to_next();
    end
`else
    run_until_done(100, 1'b0);
`endif
    check("t1_drained", 64'(exp_data_q.size()), 64'd0);

    // Zero-length command
    start_block(13'h080, 12'd0);
    to_neg();
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    check("len0_ram_en", 64'(ram_en_o), 64'd0);
    to_next();
    to_neg();
    check("len0_done_single", 64'(done_o), 64'd0);
    to_next();

    // Back-pressure with ready 1,0,0 repeating
    start_block(13'h400, 12'd8);
    run_until_done(200, 1'b1);
    check("bp_drained", 64'(exp_data_q.size()), 64'd0);
    check("bp_accepts", 64'(accepts), 64'd12);

    // Writer owns the RAM for 3 cycles; a start while busy is ignored
    start_block(13'h200, 12'd6);
    to_neg();
    to_next();
    start_i     = 1'b1;
    base_addr_i = 13'h800;
    len_i       = 12'd5;
    to_neg();
    check("wb_busy_before", 64'(busy_o), 64'd1);
    to_next();
    start_i   = 1'b0;
    wr_busy_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      check("wb_ram_en_low", 64'(ram_en_o), 64'd0);
      to_next();
    end
    wr_busy_i = 1'b0;
    run_until_done(100, 1'b0);
    check("wb_drained", 64'(exp_data_q.size()), 64'd0);
    check("wb_addr_drained", 64'(exp_addr_q.size()), 64'd0);

    // Address wrap, with low address bits ignored
    start_block(13'h1FFF, 12'd2);
    run_until_done(100, 1'b0);
    check("wrap_drained", 64'(exp_data_q.size()), 64'd0);

    // Reset in the middle of a block
    start_block(13'h600, 12'd8);
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_m_valid", 64'(m_valid_o), 64'd0);
    check("midrst_ram_en", 64'(ram_en_o), 64'd0);
    check("midrst_m_data", 64'(m_data_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    reads    = 0;
    accepts  = 0;
    clr_pend = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      to_neg();
      check("postrst_done", 64'(done_o), 64'd0);
      check("postrst_busy", 64'(busy_o), 64'd0);
      check("postrst_ram_en", 64'(ram_en_o), 64'd0);
      to_next();
    end

`ifdef ACC_DRAIN_CLEAR_EN
    // Clear-after-read, then re-drain the same block expecting zeros
    writes = 0;
    start_block(13'h100, 12'd3);
    run_until_done(100, 1'b0);
    check("clr_writes", 64'(writes), 64'd3);
    check("clr_drained", 64'(exp_data_q.size()), 64'd0);
    start_block(13'h100, 12'd3);
    run_until_done(100, 1'b0);
    check("clr_redrain_drained", 64'(exp_data_q.size()), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
